hex_display_arbiter: RTL and testbench

Shares the board's bank of active-low seven-segment displays between several requesters (rotor-position readout, ciphertext letter, debug values). Round-robin arbitration grants the display to one requester at a time. Each grant lasts a guaranteed minimum of HOLD cycles so every value stays readable. The block holds a registered snapshot of the owner's digits, decodes each nibble through the team's hex decoder, and drives all-segments-off when idle or when a digit is blanked.

---
 rtl/hex_display_pkg.sv | 16 +
 rtl/hex_decoder.sv | 33 +++
 rtl/rr_arbiter.sv | 37 +++
 rtl/hex_display_arbiter.sv | 148 ++++++++++++++
 tb/tb_hex_display_arbiter.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/hex_display_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
package hex_display_pkg;

  // Segment pattern that turns every segment of one digit off (active-low).
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // IDLE: nobody owns the display. OWN: one requester holds it.
  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } disp_state_t;

  // One hex digit.
  typedef logic [3:0] nibble_t;

endpackage

// File: rtl/hex_decoder.sv
// Hex nibble to active-low seven-segment pattern, bit order {g,f,e,d,c,b,a}.
module hex_decoder
  import hex_display_pkg::*;
(
  input  nibble_t    i_nibble,
  output logic [6:0] o_seg
);

  // Plain lookup of the sixteen glyphs 0-9, A, b, C, d, E, F.
  always_comb begin
    o_seg = SEG_BLANK;
    case (i_nibble)
      4'h0: o_seg = 7'h40;
      4'h1: o_seg = 7'h79;
      4'h2: o_seg = 7'h24;
      4'h3: o_seg = 7'h30;
      4'h4: o_seg = 7'h19;
      4'h5: o_seg = 7'h12;
      4'h6: o_seg = 7'h02;
      4'h7: o_seg = 7'h78;
      4'h8: o_seg = 7'h00;
      4'h9: o_seg = 7'h10;
      4'hA: o_seg = 7'h08;
      4'hB: o_seg = 7'h03;
      4'hC: o_seg = 7'h46;
      4'hD: o_seg = 7'h21;
      4'hE: o_seg = 7'h06;
      4'hF: o_seg = 7'h0E;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from pointer+1 with wrap,
// skipping any requester set in the exclude mask.
module rr_arbiter #(
  parameter  int NREQ = 2,
  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_pointer,
  input  logic [NREQ-1:0] i_exclude,
  output logic [NREQ-1:0] o_winner,
  output logic            o_valid
);

  logic [NREQ-1:0] w_eligible;
  int              w_dist [NREQ];
  int              w_bestDist;

  assign w_eligible = i_req & ~i_exclude;

  // Each requester's distance from pointer+1 sets its priority; the closest
  // eligible one wins. Distances are distinct, so the winner is one-hot.
  always_comb begin
    w_bestDist = NREQ;
    o_winner   = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_dist[i] = (i - int'(i_pointer) - 1 + 2 * NREQ) % NREQ;
      if (w_eligible[i] && (w_dist[i] < w_bestDist)) begin
        w_bestDist = w_dist[i];
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      o_winner[i] = w_eligible[i] && (w_dist[i] == w_bestDist);
    end
    o_valid = (w_bestDist < NREQ);
  end

endmodule

// File: rtl/hex_display_arbiter.sv
// Shares a bank of active-low seven-segment displays between NREQ requesters
// with round-robin arbitration and a guaranteed minimum hold per grant.
module hex_display_arbiter
  import hex_display_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int NDIG = 6,
  parameter int HOLD = 50_000_000
) (
  input  logic                            clock,
  input  logic                            reset_L,
  input  logic [NREQ-1:0]                 req,
  input  logic [NREQ-1:0][4*NDIG-1:0]     value,
  input  logic [NREQ-1:0][NDIG-1:0]       blank,
  output logic [NREQ-1:0]                 grant,
  output logic [NDIG-1:0][6:0]            HEX
);

  localparam int             PW      = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int             CW      = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(HOLD - 1);

  // The pointer always equals the current owner while in OWN, because it is
  // updated to the winner on every grant, so it doubles as the owner index.
  disp_state_t          r_state;
  logic [NREQ-1:0]      r_grant;
  logic [PW-1:0]        r_ptr;
  logic [CW-1:0]        r_cnt;
  logic [4*NDIG-1:0]    r_snapVal;
  logic [NDIG-1:0]      r_snapBlk;

  disp_state_t          w_stateNext;
  logic [NREQ-1:0]      w_grantNext;
  logic [PW-1:0]        w_ptrNext;
  logic [CW-1:0]        w_cntNext;
  logic [4*NDIG-1:0]    w_snapValNext;
  logic [NDIG-1:0]      w_snapBlkNext;

  logic [NREQ-1:0]      w_winner;
  logic                 w_winValid;
  logic [PW-1:0]        w_winIdx;
  logic                 w_expired;
  logic                 w_ownerReq;
  logic [NDIG-1:0][6:0] w_seg;

  // The current owner is excluded from the search, so at expiry only a
  // competitor can take over. In IDLE the grant is zero and nothing is excluded.
  rr_arbiter #(
    .NREQ (NREQ)
  ) uArb (
    .i_req     (req),
    .i_pointer (r_ptr),
    .i_exclude (r_grant),
    .o_winner  (w_winner),
    .o_valid   (w_winValid)
  );

  assign w_expired  = (r_cnt == CNT_MAX);
  assign w_ownerReq = |(req & r_grant);

  // Turn the one-hot winner into an index for snapshot loading.
  always_comb begin
    w_winIdx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_winner[i]) begin
        w_winIdx = PW'(i);
      end
    end
  end

  // Next-state logic: new grants, live snapshot update, hold counting, release.
  always_comb begin
    w_stateNext   = r_state;
    w_grantNext   = r_grant;
    w_ptrNext     = r_ptr;
    w_cntNext     = r_cnt;
    w_snapValNext = r_snapVal;
    w_snapBlkNext = r_snapBlk;
    case (r_state)
      IDLE: begin
        if (w_winValid) begin
          w_stateNext   = OWN;
          w_grantNext   = w_winner;
          w_ptrNext     = w_winIdx;
          w_cntNext     = '0;
          w_snapValNext = value[w_winIdx];
          w_snapBlkNext = blank[w_winIdx];
        end
      end
      OWN: begin
        if (w_expired && w_winValid) begin
          w_grantNext   = w_winner;
          w_ptrNext     = w_winIdx;
          w_cntNext     = '0;
          w_snapValNext = value[w_winIdx];
          w_snapBlkNext = blank[w_winIdx];
        end else if (w_expired && !w_ownerReq) begin
          w_stateNext   = IDLE;
          w_grantNext   = '0;
          w_cntNext     = '0;
          w_snapBlkNext = '1;
        end else begin
          if (!w_expired) begin
            w_cntNext = r_cnt + 1'b1;
          end
          if (w_ownerReq) begin
            w_snapValNext = value[r_ptr];
            w_snapBlkNext = blank[r_ptr];
          end
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // State and snapshot registers; reset blanks the display immediately.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_ptr     <= PW'(NREQ - 1);
      r_cnt     <= '0;
      r_snapVal <= '0;
      r_snapBlk <= '1;
    end else begin
      r_state   <= w_stateNext;
      r_grant   <= w_grantNext;
      r_ptr     <= w_ptrNext;
      r_cnt     <= w_cntNext;
      r_snapVal <= w_snapValNext;
      r_snapBlk <= w_snapBlkNext;
    end
  end

  assign grant = r_grant;

  // One decoder per digit, followed by the blank mux.
  for (genvar g = 0; g < NDIG; g++) begin : gDigit
    hex_decoder uDec (
      .i_nibble (r_snapVal[4*g +: 4]),
      .o_seg    (w_seg[g])
    );
    assign HEX[g] = r_snapBlk[g] ? SEG_BLANK : w_seg[g];
  end

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Self-checking bench for hex_display_arbiter with a cycle-level reference model.
module tb_hex_display_arbiter;

  localparam int NREQ = 2;
  localparam int NDIG = 6;
  localparam int HOLD = 4;

  logic                 clock = 1'b0;
  logic                 reset_L;
  logic [1:0]           req;
  logic [1:0][23:0]     value;
  logic [1:0][5:0]      blank;
  logic [1:0]           grant;
  logic [5:0][6:0]      HEX;

  int checks = 0;
  int errors = 0;

  // Reference model: owner (-1 when idle), round-robin pointer, number of
  // cycles the owner has held the display, and the displayed snapshot.
  int          mOwner;
  int          mPtr;
  int          mHeld;
  logic [23:0] mSnapVal;
  logic [5:0]  mSnapBlk;

  logic [6:0] segTable [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  hex_display_arbiter #(
    .NREQ (NREQ),
    .NDIG (NDIG),
    .HOLD (HOLD)
  ) dut (
    .clock   (clock),
    .reset_L (reset_L),
    .req     (req),
    .value   (value),
    .blank   (blank),
    .grant   (grant),
    .HEX     (HEX)
  );

  // Free-running clock.
  always #5 clock = ~clock;

  function automatic int pickWinner(input logic [1:0] r, input int excl);
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (mPtr + k) % NREQ;
      if (r[idx] && idx != excl) return idx;
    end
    return -1;
  endfunction

  task automatic modelReset();
    mOwner   = -1;
    mPtr     = NREQ - 1;
    mHeld    = 0;
    mSnapVal = '0;
    mSnapBlk = '1;
  endtask

  task automatic modelLoad(input int w);
    mOwner   = w;
    mPtr     = w;
    mHeld    = 1;
    mSnapVal = value[w];
    mSnapBlk = blank[w];
  endtask

  // Advance the model by one rising edge using the inputs present at that edge.
  task automatic modelEdge();
    int w;
    if (mOwner < 0) begin
      w = pickWinner(req, -1);
      if (w >= 0) modelLoad(w);
    end else if (mHeld >= HOLD) begin
      w = pickWinner(req, mOwner);
      if (w >= 0) begin
        modelLoad(w);
      end else if (!req[mOwner]) begin
        mOwner   = -1;
        mSnapBlk = '1;
      end else begin
        mSnapVal = value[mOwner];
        mSnapBlk = blank[mOwner];
      end
    end else begin
      mHeld++;
      if (req[mOwner]) begin
        mSnapVal = value[mOwner];
        mSnapBlk = blank[mOwner];
      end
    end
  endtask

  function automatic logic [1:0] expGrant();
    if (mOwner < 0) return 2'b00;
    return 2'b01 << mOwner;
  endfunction

  function automatic logic [5:0][6:0] expHex();
    logic [5:0][6:0] r;
    for (int i = 0; i < NDIG; i++) begin
      r[i] = mSnapBlk[i] ? 7'h7F : segTable[mSnapVal[4*i +: 4]];
    end
    return r;
  endfunction

  task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, " grant"}, 64'(grant), 64'(expGrant()));
    checkValue({tag, " HEX"}, 64'(HEX), 64'(expHex()));
  endtask

  // Drive inputs, let one edge pass, update the model and compare.
  task automatic applyStimulus(input logic [1:0] r, input logic [23:0] v0, input logic [23:0] v1,
                               input logic [5:0] b0, input logic [5:0] b1, input string tag);
    req      = r;
    value[0] = v0;
    value[1] = v1;
    blank[0] = b0;
    blank[1] = b1;
    @(posedge clock);
    modelEdge();
    #1;
    checkOutput(tag);
  endtask

  initial begin
    req     = '0;
    value   = '0;
    blank   = '0;
    reset_L = 1'b0;
    modelReset();
    #12;
    checkOutput("reset");
    checkValue("reset HEX const", 64'(HEX), 64'({6{7'h7F}}));
    reset_L = 1'b1;
    applyStimulus(2'b00, 24'h0, 24'h0, 6'h0, 6'h0, "idle after reset");

    // Single requester with live value update, staying owner past expiry.
    applyStimulus(2'b01, 24'h012345, 24'h0, 6'h0, 6'h0, "single grant");
    checkValue("single grant const", 64'(grant), 64'(2'b01));
    checkValue("single HEX0", 64'(HEX[0]), 64'(7'h12));
    checkValue("single HEX5", 64'(HEX[5]), 64'(7'h40));
    applyStimulus(2'b01, 24'hFFFFFF, 24'h0, 6'h0, 6'h0, "live update");
    checkValue("all F", 64'(HEX), 64'({6{7'h0E}}));
    for (int k = 0; k < 4; k++) applyStimulus(2'b01, 24'hFFFFFF, 24'h0, 6'h0, 6'h0, "sole owner");
    checkValue("sole owner const", 64'(grant), 64'(2'b01));

    // Blanking mask on digits 0 and 5.
    applyStimulus(2'b01, 24'h012345, 24'h0, 6'b100001, 6'h0, "blanking");
    checkValue("blank HEX0", 64'(HEX[0]), 64'(7'h7F));
    checkValue("blank HEX5", 64'(HEX[5]), 64'(7'h7F));
    checkValue("blank HEX1", 64'(HEX[1]), 64'(7'h19));

    // Asynchronous reset mid-grant, checked between clock edges.
    #2;
    reset_L = 1'b0;
    modelReset();
    #1;
    checkOutput("async reset");
    checkValue("async reset grant const", 64'(grant), 64'(2'b00));
    req = 2'b00;
    @(posedge clock);
    #2;
    reset_L = 1'b1;
    applyStimulus(2'b00, 24'h0, 24'h0, 6'h0, 6'h0, "idle after async reset");

    // Contention from a fresh reset: req[0] first, alternating every HOLD cycles.
    for (int k = 1; k <= 12; k++) begin
      applyStimulus(2'b11, 24'h111111, 24'h222222, 6'h0, 6'h0, "contention");
      if (k == 4) checkValue("contention end of first grant", 64'(grant), 64'(2'b01));
      if (k == 5) checkValue("contention switch", 64'(grant), 64'(2'b10));
      if (k == 9) checkValue("contention switch back", 64'(grant), 64'(2'b01));
    end
    applyStimulus(2'b00, 24'h0, 24'h0, 6'h0, 6'h0, "release to idle");

    // Early drop: owner lets go one cycle into the grant, nobody else waiting.
    applyStimulus(2'b01, 24'h9876AB, 24'h0, 6'h0, 6'h0, "early drop grant");
    for (int k = 0; k < 3; k++) applyStimulus(2'b00, 24'h555555, 24'h0, 6'h0, 6'h0, "early drop frozen");
    checkValue("early drop frozen HEX0", 64'(HEX[0]), 64'(7'h03));
    applyStimulus(2'b00, 24'h555555, 24'h0, 6'h0, 6'h0, "early drop idle");
    checkValue("early drop idle HEX", 64'(HEX), 64'({6{7'h7F}}));

    // Expiry collision: owner drops as the competitor rises on the expiry edge.
    applyStimulus(2'b01, 24'h123456, 24'h0, 6'h0, 6'h0, "collision grant");
    for (int k = 0; k < 3; k++) applyStimulus(2'b01, 24'h123456, 24'h0, 6'h0, 6'h0, "collision hold");
    applyStimulus(2'b10, 24'h123456, 24'hC0FFEE, 6'h0, 6'h0, "collision switch");
    checkValue("collision grant const", 64'(grant), 64'(2'b10));
    checkValue("collision HEX0", 64'(HEX[0]), 64'(7'h06));
    checkValue("collision HEX5", 64'(HEX[5]), 64'(7'h46));

    // Randomized traffic with sticky requests and occasional async resets.
    for (int k = 0; k < 400; k++) begin
      logic [1:0] r;
      r = req;
      if ($urandom_range(0, 3) == 0) r = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) begin
        #2;
        reset_L = 1'b0;
        modelReset();
        #1;
        checkOutput("random async reset");
        #3;
        reset_L = 1'b1;
      end
      applyStimulus(r, 24'($urandom()), 24'($urandom()),
                    6'($urandom() & $urandom() & $urandom()),
                    6'($urandom() & $urandom() & $urandom()), "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
